// File: rtl/memmu_point_reader.sv
// Single-beat AXI4 point reader: MemMU address in, decoded 64-bit point out to ExMU.
// One transaction in flight; status flags and a completed-read count for MonU.
module memmu_point_reader #(
  parameter logic [31:0] OFFSET         = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        i_SYSTEM_clk,
  input  logic        i_SYSTEM_rst,
  input  logic        i_ExMU_readValid,
  output logic        o_MemMU_readReady,
  input  logic [31:0] i_MemMU_pointReadAddress,
  output logic [31:0] o_RD_araddr,
  output logic        o_RD_arvalid,
  input  logic        i_RD_arready,
  output logic [7:0]  o_RD_arlen,
  output logic [2:0]  o_RD_arsize,
  input  logic [63:0] i_RD_rdata,
  input  logic [1:0]  i_RD_rresp,
  input  logic        i_RD_rlast,
  input  logic        i_RD_rvalid,
  output logic        o_RD_rready,
  output logic        o_point_valid,
  input  logic        i_ExMU_pointReady,
  output logic [63:0] o_point_raw,
  output logic [15:0] o_point_angleH,
  output logic [15:0] o_point_angleV,
  output logic [15:0] o_point_distR0,
  output logic [7:0]  o_point_reflR0,
  output logic [7:0]  o_point_label,
  input  logic        i_MonU_clear,
  output logic [31:0] o_status
);

  typedef enum logic [1:0] {IDLE, AR, R, OUT} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_ARM  = 16'(TIMEOUT_CYCLES - 2);

  state_t      state, stateNext;
  logic [31:0] araddrReg;
  logic [63:0] pointRaw;
  logic [15:0] timeoutCnt;
  logic [15:0] readCount;
  logic        respErr, timeoutFlag, rlastErr;
  logic        reqFire, rFire, inXfer, timeoutHit;

  assign reqFire    = (state == IDLE) && i_ExMU_readValid;
  assign rFire      = (state == R) && i_RD_rvalid;
  assign inXfer     = (state == AR) || (state == R);
  assign timeoutHit = inXfer && (timeoutCnt >= TIMEOUT_ARM);

  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) state <= IDLE;
    else               state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (i_ExMU_readValid) stateNext = AR;
      AR:   if (i_RD_arready)     stateNext = R;
      R:    if (i_RD_rvalid)      stateNext = OUT;
      OUT:  if (i_ExMU_pointReady) stateNext = IDLE;
      default:                    stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      araddrReg <= 32'h0;
      pointRaw  <= 64'h0;
    end else begin
      if (reqFire) araddrReg <= i_MemMU_pointReadAddress + OFFSET;
      if (rFire)   pointRaw  <= i_RD_rdata;
    end
  end

  // Counts AR+R cycles and saturates; the transaction itself is never aborted.
  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      timeoutCnt <= 16'h0;
    end else if (reqFire) begin
      timeoutCnt <= 16'h0;
    end else if (inXfer && (timeoutCnt != TIMEOUT_LAST)) begin
      timeoutCnt <= timeoutCnt + 16'h1;
    end
  end

  // A set or increment in the same cycle as a MonU clear takes priority.
  always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
    if (!i_SYSTEM_rst) begin
      respErr     <= 1'b0;
      timeoutFlag <= 1'b0;
      rlastErr    <= 1'b0;
      readCount   <= 16'h0;
    end else begin
      respErr     <= (respErr & ~i_MonU_clear) | (rFire && (i_RD_rresp != 2'b00));
      rlastErr    <= (rlastErr & ~i_MonU_clear) | (rFire && !i_RD_rlast);
      timeoutFlag <= (timeoutFlag & ~i_MonU_clear) | timeoutHit;
      if (rFire)             readCount <= i_MonU_clear ? 16'h1 : readCount + 16'h1;
      else if (i_MonU_clear) readCount <= 16'h0;
    end
  end

  assign o_MemMU_readReady = (state == IDLE);
  assign o_RD_arvalid      = (state == AR);
  assign o_RD_rready       = (state == R);
  assign o_point_valid     = (state == OUT);
  assign o_RD_araddr       = araddrReg;
  assign o_RD_arlen        = 8'h00;
  assign o_RD_arsize       = 3'b011;

  assign o_point_raw    = pointRaw;
  assign o_point_angleH = pointRaw[63:48];
  assign o_point_angleV = pointRaw[47:32];
  assign o_point_distR0 = pointRaw[31:16];
  assign o_point_reflR0 = pointRaw[15:8];
  assign o_point_label  = pointRaw[7:0];

  assign o_status = {readCount, 12'h000, rlastErr, timeoutFlag, respErr, (state != IDLE)};

endmodule

// File: doc/memmu_point_reader.md
# memmu_point_reader

Read-side companion to the memory management unit. It takes a point read address that the MemMU has already resolved from the ExMU point ID and issues a single-beat AXI4 read. It decodes the returned 64-bit point word into its fields and holds the point for the ExMU behind a valid/ready handshake. It sits between MemMU, the DDR/BRAM read port and ExMU, and reports status to MonU.

## Interface
- OFFSET, 0: base byte address added to every request address.
- TIMEOUT_CYCLES, 1024: number of cycles a transaction may spend in AR+R before the timeout flag is set. Legal range 2..65535.
- i_SYSTEM_clk  in  1  sole clock.
- i_SYSTEM_rst  in  1  reset, asynchronous, active-low.
- i_ExMU_readValid  in  1  read request valid.
- o_MemMU_readReady  out  1  request accepted when readValid & readReady.
- i_MemMU_pointReadAddress  in  32  point byte address from MemMU.
- o_RD_araddr  out  32  AXI read address.
- o_RD_arvalid  out  1  AXI read address valid.
- i_RD_arready  in  1  AXI read address ready.
- o_RD_arlen  out  8  constant 0.
- o_RD_arsize  out  3  constant 3'b011.
- i_RD_rdata  in  64  AXI read data.
- i_RD_rresp  in  2  AXI read response.
- i_RD_rlast  in  1  AXI last beat.
- i_RD_rvalid  in  1  AXI read data valid.
- o_RD_rready  out  1  AXI read data ready.
- o_point_valid  out  1  decoded point available.
- i_ExMU_pointReady  in  1  point consumed when valid & ready.
- o_point_raw  out  64  raw word.
- o_point_angleH  out  16  raw[63:48].
- o_point_angleV  out  16  raw[47:32].
- o_point_distR0  out  16  raw[31:16].
- o_point_reflR0  out  8  raw[15:8].
- o_point_label  out  8  raw[7:0].
- i_MonU_clear  in  1  synchronous clear of status counters and flags.
- o_status  out  32  [0] busy, [1] resp_error sticky, [2] timeout sticky, [3] rlast_error sticky, [15:4] 0, [31:16] completed-read count.

## Operation
- FSM states and transitions:
  - IDLE: readReady=1. On a request handshake, latch araddr = address + OFFSET (mod 2^32), set arvalid=1, clear the timeout counter, go to AR.
  - AR: hold araddr and arvalid stable until arready. On arready, arvalid=0 and rready=1, go to R.
  - R: on rvalid, latch rdata into o_point_raw, rready=0, point_valid=1, increment the read count, go to OUT.
  - OUT: hold all point outputs stable until pointReady. Then point_valid=0, go to IDLE.
- Only one transaction is outstanding at a time. rready is never asserted outside R.
- rresp != 2'b00 sets resp_error. The data is still forwarded unchanged.
- rlast == 0 on the beat sets rlast_error. The beat is still treated as the only beat.
- Timeout: a 16-bit counter increments each cycle in AR or R. When it reaches TIMEOUT_CYCLES-1, the timeout flag is set and the counter saturates.
  - The transaction is never aborted, which preserves AXI compliance.
- Decoded field outputs are pure slices of o_point_raw.
- busy = state != IDLE.
- The read count is 16 bits and wraps from 0xFFFF to 0.
- i_MonU_clear zeroes the count and all sticky flags. If a set or increment occurs in the same cycle as the clear, the set or increment wins: the flag ends at 1 and the count ends at 1.

## Timing
- Reset (asserted low, asynchronous):
  - FSM returns to IDLE.
  - o_RD_araddr, o_RD_arvalid, o_RD_rready, o_point_valid, o_point_raw, o_status and all counters go to 0.
  - o_MemMU_readReady is decoded from IDLE and reads 1, but no flop updates while reset is held, so no request is captured.
- Reset asserted mid-transaction drops arvalid and rready immediately and discards the pending point.
- Minimum latency, with arready and rvalid tied high:
  - request handshake at cycle 0;
  - arvalid at cycle 1, accepted at cycle 1;
  - rready at cycle 2, beat captured at cycle 2;
  - point_valid at cycle 3.
- With pointReady high at cycle 3, readReady is 1 at cycle 4. Peak throughput is one point per 4 cycles.
- arvalid, araddr and point outputs never change while waiting for the corresponding ready.
- Beats that arrive while rready=0 are not consumed. That condition is an interconnect error and is not handled.

## Test plan
- OFFSET=0x1000, request addr 0x20, arready/rvalid tied 1, rdata=0x0123_4567_89AB_CDEF -> araddr=0x1020 at cycle 1; point_valid at cycle 3; angleH=0x0123, angleV=0x4567, distR0=0x89AB, reflR0=0xCD, label=0xEF; status[31:16]=1.
- arready delayed 5 cycles, rvalid delayed 7 cycles, pointReady held low 4 cycles -> araddr/arvalid stable throughout the wait; point outputs stable; exactly one count increment; no new request accepted until pointReady.
- rresp=2'b10 with rlast=0 -> data forwarded; status[1]=1 and status[3]=1; i_MonU_clear then clears both bits; a clear coinciding with a new error leaves the bit at 1.
- TIMEOUT_CYCLES=8, arready withheld 20 cycles -> status[2] set on the 8th cycle in AR; arvalid remains 1; transaction completes normally afterwards.
- OFFSET=0xFFFF_FFF0, addr 0x20 -> araddr=0x0000_0010 (wrap). Separately, preload the count to 0xFFFF and complete one read -> count reads 0.
- Reset pulled low while in R -> rready and arvalid drop asynchronously; after release the FSM is in IDLE, status=0, and the next request completes normally.
